// File: rtl/rdc_prec_pipe_pkg.sv
// rdc_prec_pipe_pkg: number-format and rounding-mode types shared by the precision reducer
package rdc_prec_pipe_pkg;
  typedef enum logic {INT, FXP} dtype_t;
  typedef enum logic {Disable, Enable} sign_t;
  typedef struct packed {
    dtype_t dtype;
    sign_t  sign;
    int     prec;
    int     frac;
  } dconf_t;
  typedef enum logic [1:0] {TRUNC = 2'b00, RHU = 2'b01, RNE = 2'b10} rnd_mode_t;
  function automatic int frac_of(dconf_t c);
    return c.dtype == FXP ? c.frac : 0;
  endfunction
endpackage

// File: rtl/rdc_prec_pipe_lane.sv
// rdc_prec_lane: one lane of rounding (stage 1) and saturation (stage 2)
module rdc_prec_lane import rdc_prec_pipe_pkg::*; #(
  parameter dconf_t I_CONF = '{FXP, Enable, 16, 4},
  parameter dconf_t O_CONF = '{FXP, Enable, 8, 3}
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     en,
  input  logic [I_CONF.prec-1:0]   in_data,
  input  logic [1:0]               in_mode,
  output logic [O_CONF.prec-1:0]   out_data,
  output logic                     out_ovf,
  output logic                     out_udf,
  output logic                     out_rnd
);
  localparam int IP = I_CONF.prec;
  localparam int OP = O_CONF.prec;
  localparam int SH = frac_of(I_CONF) - frac_of(O_CONF);
  localparam int W1 = IP - SH + 1;
  localparam int RW = W1 + 1;
  localparam logic ISG = I_CONF.sign == Enable;
  localparam logic OSG = O_CONF.sign == Enable;
  localparam logic [IP:0] HALF_M = (IP+1)'(SH > 0 ? 64'd1 << (SH - 1) : 64'd0);
  localparam logic [IP:0] LOW_M = (IP+1)'(SH > 1 ? (64'd1 << (SH - 1)) - 64'd1 : 64'd0);
  localparam logic signed [RW-1:0] MAXV = RW'(OSG ? (64'sd1 <<< (OP - 1)) - 64'sd1 : (64'sd1 <<< OP) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = RW'(OSG ? -(64'sd1 <<< (OP - 1)) : 64'sd0);
  logic [IP:0] xs;
  logic [W1-1:0] kept, r_d, r_q;
  logic half, below, up, rnd1_d, rnd1_q;
  logic signed [RW-1:0] rv;
  logic [OP-1:0] dat_d, dat_q;
  logic ovf, udf, ovf_d, ovf_q, udf_d, udf_q, rnd2_d, rnd2_q;
  always_comb begin
    xs = {ISG & in_data[IP-1], in_data};
    kept = W1'($signed(xs) >>> SH);
    half = |(xs & HALF_M);
    below = |(xs & LOW_M);
    up = in_mode == RHU ? half : in_mode == RNE ? half & (below | kept[0]) : 1'b0;
    r_d = en ? kept + W1'(up) : r_q;
    rnd1_d = en ? half | below : rnd1_q;
    rv = {ISG & r_q[W1-1], r_q};
    ovf = rv > MAXV;
    udf = rv < MINV;
    dat_d = en ? (ovf ? MAXV[OP-1:0] : udf ? MINV[OP-1:0] : rv[OP-1:0]) : dat_q;
    ovf_d = en ? ovf : ovf_q;
    udf_d = en ? udf : udf_q;
    rnd2_d = en ? rnd1_q : rnd2_q;
  end
  always_ff @(posedge clk)
    if (!reset_) begin
      r_q <= '0;
      rnd1_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      rnd2_q <= 1'b0;
    end else begin
      r_q <= r_d;
      rnd1_q <= rnd1_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      rnd2_q <= rnd2_d;
    end
  assign out_data = dat_q;
  assign out_ovf = ovf_q;
  assign out_udf = udf_q;
  assign out_rnd = rnd2_q;
endmodule

// File: rtl/rdc_prec_pipe.sv
// rdc_prec_pipe: multi-lane two-stage streaming precision reducer with event counters
module rdc_prec_pipe import rdc_prec_pipe_pkg::*; #(
  parameter dconf_t I_CONF = '{FXP, Enable, 16, 4},
  parameter dconf_t O_CONF = '{FXP, Enable, 8, 3},
  parameter int     LANES  = 4,
  parameter int     CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*I_CONF.prec-1:0]  in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*O_CONF.prec-1:0]  out_data,
  output logic [LANES-1:0]              out_ovf,
  output logic [LANES-1:0]              out_udf,
  output logic [LANES-1:0]              out_rnd,
  input  logic                          clr_cnt,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic [CNT_W-1:0]              udf_cnt,
  output logic [CNT_W-1:0]              rnd_cnt
);
  localparam int IP = I_CONF.prec;
  localparam int OP = O_CONF.prec;
  localparam int IF = frac_of(I_CONF);
  localparam int OF = frac_of(O_CONF);
  if (IF < OF || IP - IF < OP - OF) begin : g_bad_conf
    $error("rdc_prec_pipe: O_CONF must not have more frac or integer bits than I_CONF");
  end
  logic en, hs, v1_d, v1_q, v2_d, v2_q;
  logic [2:0] hit;
  logic [2:0][CNT_W-1:0] cnt_d, cnt_q;
  assign en = !v2_q || out_ready;
  assign in_ready = en;
  assign out_valid = v2_q;
  assign hs = v2_q && out_ready;
  assign hit = {3{hs}} & {|out_rnd, |out_udf, |out_ovf};
  always_comb begin
    v1_d = en ? in_valid : v1_q;
    v2_d = en ? v1_q : v2_q;
    for (int k = 0; k < 3; k++)
      cnt_d[k] = clr_cnt ? '0 : hit[k] && !(&cnt_q[k]) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
  end
  always_ff @(posedge clk)
    if (!reset_) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      cnt_q <= cnt_d;
    end
  assign ovf_cnt = cnt_q[0];
  assign udf_cnt = cnt_q[1];
  assign rnd_cnt = cnt_q[2];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rdc_prec_lane #(.I_CONF(I_CONF), .O_CONF(O_CONF)) u_lane (
      .clk      (clk),
      .reset_   (reset_),
      .en       (en),
      .in_data  (in_data[i*IP +: IP]),
      .in_mode  (in_mode),
      .out_data (out_data[i*OP +: OP]),
      .out_ovf  (out_ovf[i]),
      .out_udf  (out_udf[i]),
      .out_rnd  (out_rnd[i])
    );
  end
endmodule

// File: tb/tb_rdc_prec_pipe.sv
// tb_rdc_prec_pipe: directed and scoreboarded checks of the precision reducer pipeline
module tb_rdc_prec_pipe;
  logic clk, reset_, in_valid, out_ready, clr_cnt;
  logic [63:0] in_data;
  logic [1:0] in_mode;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] out_data, out_data4;
  logic [3:0] out_ovf, out_udf, out_rnd, out_ovf4, out_udf4, out_rnd4;
  logic [15:0] ovf_cnt, udf_cnt, rnd_cnt;
  logic [3:0] ovf_cnt4, udf_cnt4, rnd_cnt4;
  int n_chk = 0, n_pass = 0;
  rdc_prec_pipe dut (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_udf(out_udf), .out_rnd(out_rnd),
    .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt), .rnd_cnt(rnd_cnt)
  );
  rdc_prec_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_ovf(out_ovf4), .out_udf(out_udf4), .out_rnd(out_rnd4),
    .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt4), .udf_cnt(udf_cnt4), .rnd_cnt(rnd_cnt4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic one(input string tag, input logic [15:0] x, input logic [1:0] m,
                     input logic [7:0] ed, input logic eo, input logic eu, input logic er);
    in_valid = 1'b1;
    in_data = {16'h0, 16'h0, 16'h0008, x};
    in_mode = m;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    in_data = '0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
    tick;
    chk({tag, "_lat2"}, 64'(out_valid), 64'(1));
    chk({tag, "_data"}, 64'(out_data), 64'({16'h0, 8'h04, ed}));
    chk({tag, "_flags"}, 64'({out_ovf, out_udf, out_rnd}), 64'({3'b0, eo, 3'b0, eu, 3'b0, er}));
    tick;
  endtask
  function automatic logic [10:0] ref_lane(input logic [15:0] x, input logic [1:0] m);
    int v, fl, q;
    logic r, o, u;
    v = int'($signed(x));
    fl = v >>> 1;
    r = (v & 1) != 0;
    q = m == 2'b01 ? (v + 1) >>> 1 : m == 2'b10 ? fl + ((r && (fl & 1) != 0) ? 1 : 0) : fl;
    o = q > 127;
    u = q < -128;
    return {o, u, r, o ? 8'h7F : u ? 8'h80 : 8'(q)};
  endfunction
  initial begin
    logic [31:0] held;
    logic held_v, seen;
    logic [43:0] q[$];
    logic [43:0] e;
    logic [10:0] rl;
    int sent, got;
    reset_ = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; in_data = '0; in_mode = 2'b00;
    tick;
    tick;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'({out_data, out_ovf, out_udf, out_rnd}), 64'(0));
    chk("rst_cnt", 64'({ovf_cnt, udf_cnt, rnd_cnt}), 64'(0));
    reset_ = 1'b1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'(1));
    for (int m = 0; m < 4; m++) begin
      one("ex175", 16'h001C, 2'(m), 8'h0E, 1'b0, 1'b0, 1'b0);
      one("ex75", 16'h0078, 2'(m), 8'h3C, 1'b0, 1'b0, 1'b0);
    end
    one("r85_trunc", 16'h0011, 2'b00, 8'h08, 1'b0, 1'b0, 1'b1);
    one("r85_rhu", 16'h0011, 2'b01, 8'h09, 1'b0, 1'b0, 1'b1);
    one("r85_rne", 16'h0011, 2'b10, 8'h08, 1'b0, 1'b0, 1'b1);
    one("r85_rsvd", 16'h0011, 2'b11, 8'h08, 1'b0, 1'b0, 1'b1);
    one("r95_trunc", 16'h0013, 2'b00, 8'h09, 1'b0, 1'b0, 1'b1);
    one("r95_rhu", 16'h0013, 2'b01, 8'h0A, 1'b0, 1'b0, 1'b1);
    one("r95_rne", 16'h0013, 2'b10, 8'h0A, 1'b0, 1'b0, 1'b1);
    one("sat_pos", 16'h0140, 2'b00, 8'h7F, 1'b1, 1'b0, 1'b0);
    one("sat_neg", 16'hFEC0, 2'b00, 8'h80, 1'b0, 1'b1, 1'b0);
    one("sat_ff_rhu", 16'h00FF, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b1);
    one("sat_ff_trunc", 16'h00FF, 2'b00, 8'h7F, 1'b0, 1'b0, 1'b1);
    chk("cnt_ovf", 64'(ovf_cnt), 64'(2));
    chk("cnt_udf", 64'(udf_cnt), 64'(1));
    chk("cnt_rnd", 64'(rnd_cnt), 64'(9));
    in_valid = 1'b1; in_data = {48'h0, 16'h0140}; in_mode = 2'b00;
    tick;
    in_valid = 1'b0;
    tick;
    chk("clr_pre_valid", 64'(out_valid), 64'(1));
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    chk("clr_ovf", 64'(ovf_cnt), 64'(0));
    chk("clr_all", 64'({udf_cnt, rnd_cnt, ovf_cnt4}), 64'(0));
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) tick;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    chk("cnt_ovf20", 64'(ovf_cnt), 64'(20));
    chk("cnt4_sat", 64'(ovf_cnt4), 64'(4'hF));
    sent = 0; got = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid = sent < 10;
      in_data = {16'h0, 16'((sent + 1) * 16), 16'h0, 16'((sent + 1) * 8)};
      in_mode = 2'(c);
      #1;
      chk("bp_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (held_v) chk("bp_hold", 64'({out_valid, out_data}), 64'({1'b1, held}));
      held_v = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        chk("bp_beat", 64'({out_ovf, out_udf, out_rnd, out_data}),
            64'({12'h0, 8'h0, 8'((got + 1) * 8), 8'h0, 8'((got + 1) * 4)}));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(got), 64'(10));
    tick;
    chk("bp_no_extra", 64'(out_valid), 64'(0));
    in_valid = 1'b1; in_data = {48'h0, 16'h0140};
    tick;
    in_data = {48'h0, 16'h0013};
    tick;
    in_valid = 1'b0; out_ready = 1'b0; reset_ = 1'b0;
    tick;
    reset_ = 1'b1; out_ready = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", 64'({out_data, out_ovf, out_udf, out_rnd}), 64'(0));
    chk("mid_rst_cnt", 64'({ovf_cnt, udf_cnt, rnd_cnt}), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      seen |= out_valid;
    end
    chk("mid_rst_stale", 64'(seen), 64'(0));
    sent = 0; got = 0;
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_mode = 2'($urandom_range(0, 3));
      for (int l = 0; l < 4; l++)
        in_data[l*16 +: 16] = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 64'(out_data), 64'(0) - 64'(1));
        else begin
          e = q.pop_front();
          chk("rnd_beat", 64'({out_ovf, out_udf, out_rnd, out_data}), 64'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e = '0;
        for (int l = 0; l < 4; l++) begin
          rl = ref_lane(in_data[l*16 +: 16], in_mode);
          e[l*8 +: 8] = rl[7:0];
          e[32 + l] = rl[8];
          e[36 + l] = rl[9];
          e[40 + l] = rl[10];
        end
        q.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_count", 64'(got), 64'(1000));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rdc_prec_pipe.md
# rdc_prec_pipe

Pipelined, multi-lane, streaming precision reducer. Converts `LANES` packed INT/FXP values from `I_CONF` to `O_CONF` format. Each beat carries a runtime-selectable rounding mode, and each lane saturates on overflow or underflow. The block sits between wide accumulators (MAC/adder trees) and narrow activation/storage paths. It adds a valid/ready handshake, a fixed 2-cycle latency and saturating event counters to the combinational precision reducer.

## Interface
Parameters:
- `I_CONF`, default `{FXP, Enable, 16, 4}` (`dconf_t`): input format; sign, prec, frac.
- `O_CONF`, default `{FXP, Enable, 8, 3}` (`dconf_t`): output format. Legal only when `I_FRAC >= O_FRAC` and `I_PREC-I_FRAC >= O_PREC-O_FRAC`.
- `LANES`, default 4: lanes processed per beat.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clk` in 1: clock.
- `reset_` in 1: synchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_data` in `LANES*I_PREC`: packed lanes, lane 0 in the LSBs.
- `in_mode` in 2: `rnd_mode_t`, sampled together with the beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out `LANES*O_PREC`: reduced lanes.
- `out_ovf`, `out_udf`, `out_rnd` out `LANES` each: per-lane flags aligned with `out_data`.
- `clr_cnt` in 1: synchronous counter clear.
- `ovf_cnt`, `udf_cnt`, `rnd_cnt` out `CNT_W` each: event counters.

## Operation
Per lane, with `SH = I_FRAC - O_FRAC`:
- **Rounding, by mode:**
  - `TRUNC` (00): arithmetic right shift by `SH`, i.e. floor.
  - `RHU` (01): add `2^(SH-1)`, then floor.
  - `RNE` (10): round half to even. A tie is when the discarded bits equal exactly `100…0`; on a tie, round up only if the kept LSB is 1.
  - `11`: reserved, behaves as `TRUNC`.
  - When `SH = 0` every mode is an identity and `rnd` is always 0.
- **Intermediate width:** rounding is computed at `I_PREC-SH+1` bits, so the round-up carry is never lost.
- **`rnd`:** set to 1 when any discarded bit is nonzero, regardless of mode.
- **Saturation:** applied after rounding.
  - Value above the `O_CONF` maximum: `ovf=1`, output is the maximum (signed `0x7F…`, unsigned all ones).
  - Value below the minimum: `udf=1`, output is the minimum (signed `0x80…`, unsigned 0).
  - `ovf` and `udf` are mutually exclusive.
  - `rnd` may coexist with either of them.
- **Unsigned configs:** a negative input cannot occur.
- **INT type:** frac is 0, so only saturation applies.
- **Counters:**
  - On each output handshake (`out_valid && out_ready`), each counter increments by 1 if any lane asserts the corresponding flag.
  - Counters saturate at all ones; they never wrap.
  - When `clr_cnt` coincides with an increment, the clear wins and the counter becomes 0.

## Timing
- **Pipeline:**
  - Stage 1 registers the rounded intermediate value, the mode decision and `rnd`.
  - Stage 2 registers saturated data, `ovf` and `udf`.
- **Latency:** 2 cycles from input handshake to `out_valid`, when not stalled.
- **Enable:** `en = !out_valid || out_ready`, and `in_ready = en`. Throughput is 1 beat per cycle, and there are no bubbles under continuous `out_ready`.
- **Stall behaviour:**
  - While `en=0`, both stages hold and `out_data` and the flags remain stable.
  - A stage-1 valid bit with no data advances into an empty stage 2 (bubble collapse comes from the enable rule).
- **Handshake rule:** `out_valid` must not drop without a handshake.
- **Reset:** while `reset_=0` at the clock edge, all outputs go to 0 on that edge: valid bits, data, flags and counters.
  - A reset mid-stream discards in-flight beats; no partial beat is emitted.
  - `in_ready` is 1 after reset.
- **Mode changes:** `in_mode` may change on every beat; each beat uses its own sampled mode.

## Structure
- **Shared package:** add `rnd_mode_t` (`TRUNC`, `RHU`, `RNE`) to `perceptron.svh`, next to `dconf_t`/`dtype_t`.
- **Sub-module `rdc_prec_lane`:** one lane's two-stage datapath, with `en` and `reset_` inputs. It is instantiated `LANES` times by generate.
- **Top level:** holds the valid bits, enable logic, flag OR-reduction and counters.
- **Elaboration check:** the legality condition on `I_CONF`/`O_CONF` is checked at elaboration with `$error`.

## Test plan
Default configuration throughout (16.4 to 8.3 signed FXP).
- **Exact values:** lane 0 = `0x001C` (1.75) gives `0x0E`, and `0x0078` (7.5) gives `0x3C`, in every mode with all flags 0; `out_valid` asserts exactly 2 cycles after `in_valid`.
- **Rounding modes:**
  - `0x0011` (8.5 LSB) gives `0x08` / `0x09` / `0x08` for TRUNC / RHU / RNE.
  - `0x0013` (9.5 LSB) gives `0x09` / `0x0A` / `0x0A`.
  - `rnd=1` in all six cases.
- **Saturation:**
  - `0x0140` (20.0) gives `0x7F` with `ovf=1`.
  - `0xFEC0` (-20.0) gives `0x80` with `udf=1`.
  - `0x00FF` in RHU gives `0x7F` with `ovf=1` and `rnd=1`; in TRUNC it gives `0x7F` with `ovf=0` and `rnd=1`.
- **Backpressure:** stream 10 beats with `out_ready` toggling in a 1-0-0-1 pattern. Every beat must arrive exactly once, in order, with stable data while stalled, and `in_ready` must equal `!out_valid || out_ready`.
- **Counters:**
  - Pulse `clr_cnt` in the same cycle as an `ovf` beat handshake; `ovf_cnt` must read 0.
  - With `CNT_W=4`, 20 `ovf` beats give `ovf_cnt = 0xF`.
- **Reset mid-stream:** assert `reset_=0` for 1 cycle with 2 beats in flight. `out_valid`, counters and data must be 0 on the next cycle, and no stale beat may emit afterwards.
- **Random run:** 1000 random beats in random modes, checked against the `FxpCalc` reference.
